// File: rtl/regfile_sequencer.sv
// Micro-op sequencer for a single-read/single-write register file: reads rs1 then rs2,
// presents operands to an external ALU, writes the result back, and arbitrates host loads.
module regfile_sequencer #(
    parameter int unsigned N_REGS     = 8,
    parameter int unsigned REG_WIDTH  = 8,
    parameter int unsigned ADDR_WIDTH = $clog2(N_REGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_rs1,
    input  logic [ADDR_WIDTH-1:0] req_rs2,
    input  logic [ADDR_WIDTH-1:0] req_rd,
    input  logic                  req_wb,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [ADDR_WIDTH-1:0] ld_reg,
    input  logic [REG_WIDTH-1:0]  ld_data,
    output logic [REG_WIDTH-1:0]  alu_a,
    output logic [REG_WIDTH-1:0]  alu_b,
    input  logic [REG_WIDTH-1:0]  alu_result,
    output logic                  done,
    output logic [REG_WIDTH-1:0]  result,
    output logic [ADDR_WIDTH-1:0] rf_wreg_index,
    output logic [REG_WIDTH-1:0]  rf_data_in,
    output logic                  rf_write_enable,
    output logic [ADDR_WIDTH-1:0] rf_rreg_index,
    input  logic [REG_WIDTH-1:0]  rf_data_out
);

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StRdA  = 3'd1;
    localparam logic [2:0] StRdB  = 3'd2;
    localparam logic [2:0] StCapB = 3'd3;
    localparam logic [2:0] StWb   = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] rs1_q, rs2_q, rd_q;
    logic                  wb_q;
    logic [REG_WIDTH-1:0]  op_a_q, op_b_q, result_q;
    logic                  done_q;
    logic                  idle;
    logic                  accept;

    // Both handshakes are masked during reset so a load cannot race the register-file clear.
    assign idle      = (state_q == StIdle) && !reset;
    assign ld_ready  = idle;
    assign req_ready = idle && !ld_valid;
    assign accept    = req_valid && req_ready;

    assign alu_a  = op_a_q;
    assign alu_b  = op_b_q;
    assign done   = done_q;
    assign result = result_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (accept) state_d = StRdA;
            StRdA:   state_d = StRdB;
            StRdB:   state_d = StCapB;
            StCapB:  state_d = StWb;
            StWb:    state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        rf_write_enable = 1'b0;
        rf_wreg_index   = '0;
        rf_data_in      = '0;
        rf_rreg_index   = '0;
        if (!reset) begin
            case (state_q)
                StIdle: begin
                    if (ld_valid) begin
                        rf_write_enable = 1'b1;
                        rf_wreg_index   = ld_reg;
                        rf_data_in      = ld_data;
                    end
                end
                StRdA: rf_rreg_index = rs1_q;
                StRdB: rf_rreg_index = rs2_q;
                StWb: begin
                    rf_write_enable = wb_q;
                    rf_wreg_index   = rd_q;
                    rf_data_in      = alu_result;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            rs1_q    <= '0;
            rs2_q    <= '0;
            rd_q     <= '0;
            wb_q     <= 1'b0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == StWb);
            if (accept) begin
                rs1_q <= req_rs1;
                rs2_q <= req_rs2;
                rd_q  <= req_rd;
                wb_q  <= req_wb;
            end
            // Read data lags the index by one cycle, so each capture sits one state late.
            if (state_q == StRdB) op_a_q <= rf_data_out;
            if (state_q == StCapB) op_b_q <= rf_data_out;
            if (state_q == StWb) result_q <= alu_result;
        end
    end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Self-checking bench: sequencer plus a behavioural register file and adder ALU,
// checked against an array model of the register contents.
module tb_regfile_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid, req_ready, req_wb;
    logic [2:0] req_rs1, req_rs2, req_rd;
    logic       ld_valid, ld_ready;
    logic [2:0] ld_reg;
    logic [7:0] ld_data;
    logic [7:0] alu_a, alu_b, alu_result, result;
    logic       done;
    logic [2:0] rf_wreg_index, rf_rreg_index;
    logic [7:0] rf_data_in, rf_data_out;
    logic       rf_write_enable;

    logic [7:0] rf_mem [8];
    logic [7:0] model  [8];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign alu_result = alu_a + alu_b;

    // Register file: clear on reset; write has priority; read data appears next cycle.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) rf_mem[i] <= 8'h00;
            rf_data_out <= 8'h00;
        end else if (rf_write_enable) begin
            rf_mem[rf_wreg_index] <= rf_data_in;
        end else begin
            rf_data_out <= rf_mem[rf_rreg_index];
        end
    end

    regfile_sequencer #(.N_REGS(8), .REG_WIDTH(8)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_rs1         (req_rs1),
        .req_rs2         (req_rs2),
        .req_rd          (req_rd),
        .req_wb          (req_wb),
        .ld_valid        (ld_valid),
        .ld_ready        (ld_ready),
        .ld_reg          (ld_reg),
        .ld_data         (ld_data),
        .alu_a           (alu_a),
        .alu_b           (alu_b),
        .alu_result      (alu_result),
        .done            (done),
        .result          (result),
        .rf_wreg_index   (rf_wreg_index),
        .rf_data_in      (rf_data_in),
        .rf_write_enable (rf_write_enable),
        .rf_rreg_index   (rf_rreg_index),
        .rf_data_out     (rf_data_out)
    );

    typedef struct {
        bit         is_ld;
        logic [2:0] a;
        logic [2:0] b;
        logic [2:0] c;
        logic       wb;
        logic [7:0] data;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [7];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_regs(input string name);
        for (int i = 0; i < 8; i++) check(name, 32'(rf_mem[i]), 32'(model[i]));
    endtask

    task automatic do_load(input logic [2:0] r, input logic [7:0] d);
        ld_valid = 1'b1;
        ld_reg   = r;
        ld_data  = d;
        #1;
        check("ld_ready", 32'(ld_ready), 32'd1);
        check("ld_we", 32'(rf_write_enable), 32'd1);
        check("ld_widx", 32'(rf_wreg_index), 32'(r));
        check("ld_din", 32'(rf_data_in), 32'(d));
        tick();
        ld_valid = 1'b0;
        model[r] = d;
        check("ld_readback", 32'(rf_mem[r]), 32'(d));
    endtask

    // Leaves the bench just after the accept edge (cycle E+1).
    task automatic accept_op(input logic [2:0] rs1, input logic [2:0] rs2,
                             input logic [2:0] rd, input logic wb);
        int n;
        req_rs1   = rs1;
        req_rs2   = rs2;
        req_rd    = rd;
        req_wb    = wb;
        req_valid = 1'b1;
        #1;
        n = 0;
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        check("req_ready_wait", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
    endtask

    // Starts in E+1, checks every cycle through E+6 against the model.
    task automatic op_follow(input logic [2:0] rs1, input logic [2:0] rs2,
                             input logic [2:0] rd, input logic wb, output logic [7:0] res);
        logic [7:0] exp;
        exp = 8'(model[rs1] + model[rs2]);
        check("rda_ridx", 32'(rf_rreg_index), 32'(rs1));
        check("rda_we", 32'(rf_write_enable), 32'd0);
        check("rda_ready", 32'(req_ready | ld_ready), 32'd0);
        tick();
        check("rdb_ridx", 32'(rf_rreg_index), 32'(rs2));
        check("rdb_we", 32'(rf_write_enable), 32'd0);
        tick();
        check("capb_we", 32'(rf_write_enable), 32'd0);
        check("capb_done", 32'(done), 32'd0);
        tick();
        check("wb_we", 32'(rf_write_enable), 32'(wb));
        if (wb) begin
            check("wb_widx", 32'(rf_wreg_index), 32'(rd));
            check("wb_din", 32'(rf_data_in), 32'(exp));
        end
        tick();
        check("done_pulse", 32'(done), 32'd1);
        check("result", 32'(result), 32'(exp));
        check("alu_a", 32'(alu_a), 32'(model[rs1]));
        check("alu_b", 32'(alu_b), 32'(model[rs2]));
        check("ready_in_done", 32'(req_ready), 32'd1);
        res = result;
        if (wb) model[rd] = exp;
        check("rd_contents", 32'(rf_mem[rd]), 32'(model[rd]));
        tick();
        check("done_low", 32'(done), 32'd0);
    endtask

    initial begin
        logic [7:0] res, exp1, exp2;
        reset = 1'b1; req_valid = 1'b0; ld_valid = 1'b0;
        req_rs1 = '0; req_rs2 = '0; req_rd = '0; req_wb = 1'b0; ld_reg = '0; ld_data = '0;
        for (int i = 0; i < 8; i++) model[i] = 8'h00;

        vecs[0] = '{1'b1, 3'd1, 3'd0, 3'd0, 1'b0, 8'h12, 8'h00};
        vecs[1] = '{1'b1, 3'd2, 3'd0, 3'd0, 1'b0, 8'h34, 8'h00};
        vecs[2] = '{1'b0, 3'd1, 3'd2, 3'd3, 1'b1, 8'h00, 8'h46};
        vecs[3] = '{1'b1, 3'd1, 3'd0, 3'd0, 1'b0, 8'hF0, 8'h00};
        vecs[4] = '{1'b1, 3'd2, 3'd0, 3'd0, 1'b0, 8'h20, 8'h00};
        vecs[5] = '{1'b0, 3'd1, 3'd2, 3'd1, 1'b1, 8'h00, 8'h10};
        vecs[6] = '{1'b0, 3'd1, 3'd2, 3'd5, 1'b0, 8'h00, 8'h30};

        // Reset state
        ld_valid = 1'b1;
        tick(); tick();
        check("rst_ld_ready", 32'(ld_ready), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_we", 32'(rf_write_enable), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_alu_a", 32'(alu_a), 32'd0);
        check("rst_alu_b", 32'(alu_b), 32'd0);
        ld_valid = 1'b0;
        reset = 1'b0;
        #1;
        check("idle_req_ready", 32'(req_ready), 32'd1);
        check("idle_ld_ready", 32'(ld_ready), 32'd1);

        // Table-driven directed vectors
        for (int v = 0; v < 7; v++) begin
            if (vecs[v].is_ld) begin
                do_load(vecs[v].a, vecs[v].data);
            end else begin
                accept_op(vecs[v].a, vecs[v].b, vecs[v].c, vecs[v].wb);
                op_follow(vecs[v].a, vecs[v].b, vecs[v].c, vecs[v].wb, res);
                check("tbl_result", 32'(res), 32'(vecs[v].exp));
            end
        end
        check_regs("tbl_regs");

        // Load and request together: load wins, request accepted next cycle and sees the load
        ld_valid = 1'b1; ld_reg = 3'd0; ld_data = 8'h77;
        req_valid = 1'b1; req_rs1 = 3'd0; req_rs2 = 3'd1; req_rd = 3'd2; req_wb = 1'b1;
        #1;
        check("arb_req_ready", 32'(req_ready), 32'd0);
        check("arb_ld_ready", 32'(ld_ready), 32'd1);
        check("arb_we", 32'(rf_write_enable), 32'd1);
        tick();
        ld_valid = 1'b0;
        model[0] = 8'h77;
        #1;
        check("arb_req_next", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        op_follow(3'd0, 3'd1, 3'd2, 1'b1, res);

        // Load raised in RD_B waits until IDLE
        accept_op(3'd1, 3'd2, 3'd3, 1'b1);
        exp1 = 8'(model[1] + model[2]);
        tick();
        ld_valid = 1'b1; ld_reg = 3'd6; ld_data = 8'h5A;
        #1;
        check("rdb_ld_ready", 32'(ld_ready), 32'd0);
        check("rdb_ld_we", 32'(rf_write_enable), 32'd0);
        tick();
        check("capb_ld_we", 32'(rf_write_enable), 32'd0);
        tick();
        check("wb_not_ld_idx", 32'(rf_wreg_index), 32'd3);
        tick();
        check("late_ld_ready", 32'(ld_ready), 32'd1);
        check("late_ld_widx", 32'(rf_wreg_index), 32'd6);
        check("late_ld_din", 32'(rf_data_in), 32'h5A);
        check("late_done", 32'(done), 32'd1);
        check("late_result", 32'(result), 32'(exp1));
        tick();
        ld_valid = 1'b0;
        model[3] = exp1;
        model[6] = 8'h5A;
        check_regs("late_ld_regs");

        // Back-to-back ops with req_valid held high
        req_rs1 = 3'd1; req_rs2 = 3'd2; req_rd = 3'd4; req_wb = 1'b1; req_valid = 1'b1;
        #1;
        check("b2b_ready0", 32'(req_ready), 32'd1);
        exp1 = 8'(model[1] + model[2]);
        tick();
        req_rs1 = 3'd4; req_rs2 = 3'd4; req_rd = 3'd7;
        for (int k = 1; k <= 4; k++) begin
            check("b2b_busy", 32'(req_ready), 32'd0);
            tick();
        end
        check("b2b_done1", 32'(done), 32'd1);
        check("b2b_result1", 32'(result), 32'(exp1));
        check("b2b_ready_done", 32'(req_ready), 32'd1);
        model[4] = exp1;
        exp2 = 8'(model[4] + model[4]);
        tick();
        req_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            check("b2b_gap", 32'(done), 32'd0);
            tick();
        end
        check("b2b_done2", 32'(done), 32'd1);
        check("b2b_result2", 32'(result), 32'(exp2));
        model[7] = exp2;
        tick();
        check("b2b_done_low", 32'(done), 32'd0);
        check_regs("b2b_regs");

        // Randomized ops and loads against the array model
        for (int it = 0; it < 40; it++) begin
            logic [2:0] a, b, c;
            logic w;
            a = 3'($urandom_range(0, 7));
            b = 3'($urandom_range(0, 7));
            c = 3'($urandom_range(0, 7));
            w = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                do_load(a, 8'($urandom));
            end else begin
                accept_op(a, b, c, w);
                op_follow(a, b, c, w, res);
            end
        end
        check_regs("rand_regs");

        // Reset during CAP_B abandons the op
        do_load(3'd5, 8'hAA);
        accept_op(3'd1, 3'd2, 3'd5, 1'b1);
        tick(); tick();
        reset = 1'b1;
        ld_valid = 1'b1; ld_reg = 3'd5; ld_data = 8'h99;
        #1;
        check("mid_rst_we", 32'(rf_write_enable), 32'd0);
        check("mid_rst_ld_ready", 32'(ld_ready), 32'd0);
        tick();
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_result", 32'(result), 32'd0);
        check("mid_rst_we2", 32'(rf_write_enable), 32'd0);
        tick();
        reset = 1'b0;
        ld_valid = 1'b0;
        for (int i = 0; i < 8; i++) model[i] = 8'h00;
        #1;
        check("post_rst_ready", 32'(req_ready), 32'd1);
        for (int k = 0; k < 4; k++) begin
            check("post_rst_done", 32'(done), 32'd0);
            tick();
        end
        check("post_rst_result", 32'(result), 32'd0);
        check_regs("post_rst_regs");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/regfile_sequencer.md
# regfile_sequencer

Controller sitting in front of `register_file`: it sequences a two-operand register-to-register micro-op (read rs1, read rs2, present operands to an external combinational ALU, write result to rd) through the register file's single read port and single write port. It also arbitrates a host load port that writes a register directly, for initialisation and debug. All register-file control pins (`wreg_index`, `data_in`, `write_enable`, `rreg_index`) are driven only by this block.

## Interface
- `N_REGS`, default 8: number of registers in the attached register file.
- `REG_WIDTH`, default 8: data width.
- `ADDR_WIDTH`, default `$clog2(N_REGS)`: register index width.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  micro-op request.
- `req_ready`  out  1  sequencer accepts a micro-op this cycle.
- `req_rs1`, `req_rs2`, `req_rd`  in  ADDR_WIDTH each  source and destination indices.
- `req_wb`  in  1  write result to rd when 1; compute only when 0.
- `ld_valid`  in  1  host load request.
- `ld_ready`  out  1  host load accepted this cycle.
- `ld_reg`  in  ADDR_WIDTH  host load target.
- `ld_data`  in  REG_WIDTH  host load data.
- `alu_a`, `alu_b`  out  REG_WIDTH each  captured operands.
- `alu_result`  in  REG_WIDTH  combinational ALU output.
- `done`  out  1  one-cycle pulse when a micro-op completes.
- `result`  out  REG_WIDTH  last completed micro-op result; holds until the next completion.
- `rf_wreg_index`  out  ADDR_WIDTH  to `register_file.wreg_index`.
- `rf_data_in`  out  REG_WIDTH  to `register_file.data_in`.
- `rf_write_enable`  out  1  to `register_file.write_enable`.
- `rf_rreg_index`  out  ADDR_WIDTH  to `register_file.rreg_index`.
- `rf_data_out`  in  REG_WIDTH  from `register_file.data_out`.

## Operation
- Register-file contract:
  - A read index presented in a cycle with `write_enable=0` appears on `rf_data_out` in the next cycle.
  - `rf_data_out` holds its value in write cycles.
- FSM states are IDLE, RD_A, RD_B, CAP_B and WB.
- IDLE:
  - `ld_ready = 1`.
  - `req_ready = !ld_valid`, so the load port has priority.
  - When `ld_valid`, the sequencer drives `rf_write_enable=1`, `rf_wreg_index=ld_reg` and `rf_data_in=ld_data` combinationally; the write takes one cycle and the state stays IDLE.
  - When `req_valid && req_ready`, the sequencer latches rs1, rs2, rd and wb, then moves to RD_A.
- RD_A drives `rf_rreg_index=rs1`, then moves to RD_B.
- RD_B drives `rf_rreg_index=rs2` and latches `op_a <= rf_data_out` (the value of rs1), then moves to CAP_B.
- CAP_B latches `op_b <= rf_data_out` (the value of rs2), then moves to WB.
- WB:
  - Drives `rf_write_enable=wb`, `rf_wreg_index=rd` and `rf_data_in=alu_result`.
  - At the edge: `result <= alu_result`, `done <= 1`, next state IDLE.
- `alu_a`/`alu_b` always drive the `op_a`/`op_b` registers.
- `ld_ready=0` and `req_ready=0` in every non-IDLE state. A load asserted mid-op waits; it is not dropped and not reordered.
- Defaults when not specified above: `rf_write_enable=0`, `rf_wreg_index=0`, `rf_data_in=0`, `rf_rreg_index=0`.
- No read is ever issued in a write cycle.
- rs1, rs2 and rd may be equal; WB writes after both reads, so reads always see pre-op values.
- Indices ≥ N_REGS are passed through unchecked; the register file behaviour decides the outcome.

## Timing
- Reset values:
  - state IDLE; `done=0`, `result=0`, `op_a=0`, `op_b=0`.
  - `req_ready=0`, `ld_ready=0` and `rf_write_enable=0` while `reset` is high. The load path is masked during reset so it cannot race the register-file clear.
- Micro-op latency:
  - Accept edge E.
  - RD_A in cycle E+1, RD_B in E+2, CAP_B in E+3, WB in E+4.
  - `done=1` and `result` valid in E+5.
- Throughput is one micro-op per 5 cycles. `req_ready=1` again in the `done` cycle, so back-to-back accept is allowed there.
- A host load completes in the cycle it is accepted: the written value is readable by a micro-op whose RD_A falls at least one cycle later.
- Reset mid-operation:
  - Abandons the op immediately; no WB write; `done` stays 0.
  - `result` clears to 0.
- `done` is high for exactly one cycle per completed op, including ops with `wb=0`.

## Test plan
The bench ALU is `alu_result = alu_a + alu_b` (mod 256), used with the real `register_file`.
- Reset, then host-load r1=0x12, r2=0x34 -> each load takes 1 cycle with `ld_ready=1`; readback shows r1=0x12, r2=0x34.
- Op rs1=1, rs2=2, rd=3, wb=1 accepted at E -> `done` pulses at E+5 with `result=0x46`; r3=0x46; the WB write occurs exactly in cycle E+4.
- r1=0xF0, r2=0x20, op rd=1 rs1=1 rs2=2 -> `result=0x10` (wrap), r1=0x10. Then op with wb=0 -> `done` pulses but `rf_write_enable` never asserts.
- `ld_valid` and `req_valid` both asserted in IDLE -> load wins, `req_ready=0`; the request is accepted the next cycle. A load asserted during RD_B waits until IDLE, then writes.
- Two ops with `req_valid` held high continuously -> accepts 5 cycles apart, two `done` pulses 5 cycles apart; the second op reads the first op's rd value.
- Reset asserted in CAP_B -> no write to rd; `done=0`; `result=0`; all registers cleared to 0x00.
